double_frame_buffer: RTL and testbench
======================================

// Module: double_frame_buffer
// PURPOSE
//  Double-buffered pixel store that sits directly upstream of video_driver.
//  - Drawing logic writes pixels into the back buffer.
//  - video_driver's x/y scan address reads the front buffer and gets r/g/b back.
//  - A requested buffer swap is applied only at a frame boundary, so there is no tearing.
// PARAMETERS
//  WIDTH    160  logical pixels per line; must match video_driver WIDTH
//  HEIGHT   120  logical lines per frame; must match video_driver HEIGHT
//  CH_BITS  1    stored bits per colour channel; pixel word = 3*CH_BITS bits, {R,G,B}
// PORTS
//  CLOCK_25      in   1          pixel clock; all logic is on its rising edge
//  reset         in   1          synchronous, active-high
//  x             in   10         scan column from video_driver
//  y             in   9          scan line from video_driver
//  r,g,b         out  8 each     front-buffer colour for (x,y); registered
//  wr_en         in   1          write strobe; accepted only when wr_en && wr_ready
//  wr_x          in   10         write column
//  wr_y          in   9          write line
//  wr_color      in   3*CH_BITS  pixel value {R,G,B}
//  wr_ready      out  1          high when writes are accepted
//  swap_req      in   1          one-cycle pulse requesting a buffer swap
//  swap_pending  out  1          swap requested but not yet applied
//  front_sel     out  1          index (0/1) of the buffer being displayed
//  busy          out  1          clear sequencer active (always 0 without FB_CLEAR_EN)
// BEHAVIOUR
//  Reset values
//  - r=g=b=0, front_sel=0, swap_pending=0, busy=0, wr_ready=1.
//  - RAM contents are not reset.
//  Read path
//  - addr = y*WIDTH + x into buffer[front_sel]; synchronous RAM read.
//  - r/g/b valid exactly 1 cycle after x/y is presented.
//  - If x>=WIDTH or y>=HEIGHT, the output is 0 (the range check is pipelined to match the RAM latency).
//  - Each channel's CH_BITS field is replicated MSB-first to fill 8 bits.
//    Example: CH_BITS=1, bit 1 -> 8'hFF.
//  Write path
//  - Accepted writes go to buffer[~front_sel] at wr_y*WIDTH + wr_x.
//  - A write is dropped silently when wr_x>=WIDTH or wr_y>=HEIGHT.
//  - The write lands in the buffer that is "back" at the accepting edge, even when a swap applies on that same edge.
//  Swap FSM, states IDLE and PENDING
//  - IDLE -> PENDING on swap_req; swap_pending=1.
//  - swap_req in PENDING is ignored (no double swap).
//  - Frame boundary = the registered y_last!=0 and current y==0.
//  - PENDING -> IDLE on a frame boundary with busy=0: front_sel toggles and swap_pending clears on the same edge.
//  - If busy=1 at a boundary, the swap waits for the next boundary after busy falls.
//  Arithmetic
//  - The address is $clog2(WIDTH*HEIGHT) bits wide; the multiply result is truncated to this width.
//  - A block of BLOCK video_driver pixels repeats the same logical x/y; no special handling is needed for this.
// CONFIGURATION
//  FB_CLEAR_EN defined
//  - The edge that toggles front_sel also starts the clear sequencer, which walks every address 0..WIDTH*HEIGHT-1 of the new back buffer, writing 0, one address per cycle.
//  - During the walk busy=1 and wr_ready=0, and wr_en is ignored.
//  - busy=0 and wr_ready=1 on the edge after the last address is written.
//  - Reset mid-clear aborts the walk and leaves partial contents.
//  FB_CLEAR_EN undefined
//  - No sequencer; busy is tied to 0 and wr_ready to 1.
//  - The back buffer keeps its old frame after a swap.
// STRUCTURE
//  video_pkg
//  - fb_pixel_t (3*CH_BITS packed {R,G,B})
//  - FB_DEPTH = WIDTH*HEIGHT and FB_AW = $clog2(FB_DEPTH)
//  - function fb_addr(x,y)
//  - function expand_ch(), replicating a channel field to 8 bits
//  Sub-module fb_ram
//  - Simple dual-port RAM: one write port, one registered read port.
//  - Instantiated twice, one per buffer.
//  - The top level muxes the read data by a registered copy of front_sel.
// TESTING
//  1. Reset, then hold x=0,y=0 -> r=g=b=0, front_sel=0, wr_ready=1.
//  2. Write (5,7)=3'b101, swap_req, y 119->0, then read x=5,y=7 -> r=8'hFF, g=0, b=8'hFF one cycle later, front_sel=1.
//  3. Write (160,0) and (0,120), swap, read (0,0) -> no RAM change; reading x=200 -> r=g=b=0.
//  4. Two swap_req pulses within one frame -> front_sel toggles exactly once at the boundary.
//  5. FB_CLEAR_EN: after a swap, busy=1 for 19200 cycles; wr_en is ignored meanwhile; a swap_req issued then applies at the first boundary after busy=0.
//  6. FB_CLEAR_EN: assert reset mid-clear -> next cycle busy=0, wr_ready=1, front_sel=0, swap_pending=0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared frame-buffer definitions: geometry, pixel layout, address and colour helpers.
package video_pkg;

  localparam int WIDTH    = 160;
  localparam int HEIGHT   = 120;
  localparam int CH_BITS  = 1;
  localparam int PIX_BITS = 3 * CH_BITS;
  localparam int FB_DEPTH = WIDTH * HEIGHT;
  localparam int FB_AW    = $clog2(FB_DEPTH);

  // One stored pixel, packed {R,G,B}.
  typedef struct packed {
    logic [CH_BITS-1:0] r;
    logic [CH_BITS-1:0] g;
    logic [CH_BITS-1:0] b;
  } fb_pixel_t;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Linear address y*WIDTH + x, truncated to the RAM address width.
  function automatic logic [FB_AW-1:0] fb_addr(input logic [9:0] px, input logic [8:0] py);
    logic [31:0] full;
    full = ({23'd0, py} * 32'(WIDTH)) + {22'd0, px};
    return full[FB_AW-1:0];
  endfunction

  // Replicate a channel field MSB-first until it fills 8 bits.
  function automatic logic [7:0] expand_ch(input logic [CH_BITS-1:0] ch);
    logic [8*CH_BITS-1:0] rep;
    rep = {8{ch}};
    return rep[8*CH_BITS-1 -: 8];
  endfunction

endpackage

// File: rtl/double_frame_buffer_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
module fb_ram #(
  parameter int DW    = 3,
  parameter int AW    = 15,
  parameter int DEPTH = 19200
) (
  input  logic          CLOCK_25,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_reg;

  // Write port and registered read port share the pixel clock.
  always_ff @(posedge CLOCK_25) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_reg <= mem[raddr];
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/double_frame_buffer.sv
// Double-buffered pixel store feeding video_driver. Writes go to the back
// buffer, scan reads come from the front buffer, and requested swaps are
// applied only at a frame boundary.
// Optional feature macro: FB_CLEAR_EN (clear the new back buffer after each swap).
module double_frame_buffer
  import video_pkg::*;
(
  input  logic                CLOCK_25,
  input  logic                reset,
  input  logic [9:0]          x,
  input  logic [8:0]          y,
  output logic [7:0]          r,
  output logic [7:0]          g,
  output logic [7:0]          b,
  input  logic                wr_en,
  input  logic [9:0]          wr_x,
  input  logic [8:0]          wr_y,
  input  logic [PIX_BITS-1:0] wr_color,
  output logic                wr_ready,
  input  logic                swap_req,
  output logic                swap_pending,
  output logic                front_sel,
  output logic                busy
);

  swap_state_t         state_reg, state_next;
  logic                swap_fire;
  logic                front_sel_reg;
  logic                front_sel_rd_reg;
  logic                in_range_reg;
  logic [8:0]          y_last_reg;
  logic                rd_in_range;
  logic                wr_in_range;
  logic                wr_accept;
  logic                frame_boundary;
  logic                ram_we;
  logic [FB_AW-1:0]    ram_waddr;
  logic [PIX_BITS-1:0] ram_wdata;
  logic [FB_AW-1:0]    rd_addr;
  logic [PIX_BITS-1:0] ram_rdata [2];
  fb_pixel_t           rd_pix;

  assign rd_in_range    = (x < 10'(WIDTH)) && (y < 9'(HEIGHT));
  assign wr_in_range    = (wr_x < 10'(WIDTH)) && (wr_y < 9'(HEIGHT));
  assign wr_accept      = wr_en && wr_ready && wr_in_range && !reset;
  assign frame_boundary = (y_last_reg != 9'd0) && (y == 9'd0);
  assign rd_addr        = fb_addr(x, y);

  // Swap FSM: latch a request, release it at the first boundary while idle.
  always_comb begin
    state_next = state_reg;
    swap_fire  = 1'b0;
    case (state_reg)
      SWAP_IDLE: begin
        if (swap_req) begin
          state_next = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (frame_boundary && !busy) begin
          state_next = SWAP_IDLE;
          swap_fire  = 1'b1;
        end
      end
      default: state_next = SWAP_IDLE;
    endcase
  end

  // Swap state, displayed-buffer index and the read-side pipeline registers.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      state_reg        <= SWAP_IDLE;
      front_sel_reg    <= 1'b0;
      front_sel_rd_reg <= 1'b0;
      in_range_reg     <= 1'b0;
      y_last_reg       <= 9'd0;
    end else begin
      state_reg        <= state_next;
      if (swap_fire) begin
        front_sel_reg <= ~front_sel_reg;
      end
      front_sel_rd_reg <= front_sel_reg;
      in_range_reg     <= rd_in_range;
      y_last_reg       <= y;
    end
  end

`ifdef FB_CLEAR_EN
  logic             busy_reg;
  logic [FB_AW-1:0] clr_addr_reg;

  // Clear sequencer: zero the new back buffer one address per cycle after a swap.
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      busy_reg     <= 1'b0;
      clr_addr_reg <= '0;
    end else if (swap_fire) begin
      busy_reg     <= 1'b1;
      clr_addr_reg <= '0;
    end else if (busy_reg) begin
      if (clr_addr_reg == FB_AW'(FB_DEPTH - 1)) begin
        busy_reg <= 1'b0;
      end
      clr_addr_reg <= clr_addr_reg + 1'b1;
    end
  end

  assign busy      = busy_reg;
  assign wr_ready  = ~busy_reg;
  assign ram_we    = busy_reg || wr_accept;
  assign ram_waddr = busy_reg ? clr_addr_reg : fb_addr(wr_x, wr_y);
  assign ram_wdata = busy_reg ? '0 : wr_color;
`else
  assign busy      = 1'b0;
  assign wr_ready  = 1'b1;
  assign ram_we    = wr_accept;
  assign ram_waddr = fb_addr(wr_x, wr_y);
  assign ram_wdata = wr_color;
`endif

  // One RAM per buffer; only the current back buffer sees write enables.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      fb_ram #(
        .DW    (PIX_BITS),
        .AW    (FB_AW),
        .DEPTH (FB_DEPTH)
      ) u_ram (
        .CLOCK_25 (CLOCK_25),
        .we       (ram_we && (front_sel_reg != 1'(gi))),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .raddr    (rd_addr),
        .rdata    (ram_rdata[gi])
      );
    end
  endgenerate

  // The read mux follows front_sel as it was when the address was sampled.
  assign rd_pix = fb_pixel_t'(ram_rdata[front_sel_rd_reg]);

  assign r            = in_range_reg ? expand_ch(rd_pix.r) : 8'd0;
  assign g            = in_range_reg ? expand_ch(rd_pix.g) : 8'd0;
  assign b            = in_range_reg ? expand_ch(rd_pix.b) : 8'd0;
  assign swap_pending = (state_reg == SWAP_PENDING);
  assign front_sel    = front_sel_reg;

endmodule

// File: tb/tb_double_frame_buffer.sv
// Self-checking bench for double_frame_buffer (default build and FB_CLEAR_EN build).
module tb_double_frame_buffer;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;

  logic       CLOCK_25 = 1'b0;
  logic       reset;
  logic [9:0] x;
  logic [8:0] y;
  logic [7:0] r, g, b;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic [2:0] wr_color;
  logic       wr_ready;
  logic       swap_req;
  logic       swap_pending;
  logic       front_sel;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 CLOCK_25 = ~CLOCK_25;

  double_frame_buffer dut (
    .CLOCK_25     (CLOCK_25),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .r            (r),
    .g            (g),
    .b            (b),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_color     (wr_color),
    .wr_ready     (wr_ready),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .front_sel    (front_sel),
    .busy         (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: two pixel arrays, which one is shown, a pending flag,
  // and the number of clear cycles still to run.
  logic [2:0] mbuf   [2][N];
  bit         mknown [2][N];
  int         m_front, m_pending, m_yprev, m_busy_left;
  bit         exp_known;
  logic [7:0] exp_r, exp_g, exp_b;

  initial begin
    for (int i = 0; i < N; i++) begin
      mknown[0][i] = 1'b0;
      mknown[1][i] = 1'b0;
    end
    m_front = 0; m_pending = 0; m_yprev = 0; m_busy_left = 0;
    exp_known = 1'b0; exp_r = 8'd0; exp_g = 8'd0; exp_b = 8'd0;
  end

  always @(posedge CLOCK_25) begin
    int  a;
    int  bk;
    bit  was_busy;
    cyc++;
    if (reset) begin
      m_front = 0; m_pending = 0; m_yprev = 0; m_busy_left = 0;
      exp_known = 1'b1; exp_r = 8'd0; exp_g = 8'd0; exp_b = 8'd0;
    end else begin
      was_busy = (m_busy_left > 0);
      bk = 1 - m_front;
      if (x < W && y < H) begin
        a = y * W + x;
        exp_known = mknown[m_front][a];
        exp_r = mbuf[m_front][a][2] ? 8'hFF : 8'h00;
        exp_g = mbuf[m_front][a][1] ? 8'hFF : 8'h00;
        exp_b = mbuf[m_front][a][0] ? 8'hFF : 8'h00;
      end else begin
        exp_known = 1'b1; exp_r = 8'd0; exp_g = 8'd0; exp_b = 8'd0;
      end
      if (wr_en && !was_busy && wr_x < W && wr_y < H) begin
        a = wr_y * W + wr_x;
        mbuf[bk][a]   = wr_color;
        mknown[bk][a] = 1'b1;
      end
      if (m_busy_left > 0) m_busy_left--;
      if (m_pending != 0 && m_yprev != 0 && y == 0 && !was_busy) begin
        m_front   = bk;
        m_pending = 0;
`ifdef FB_CLEAR_EN
        // Reads never see the back buffer, so zero it all at once here.
        m_busy_left = N;
        for (int i = 0; i < N; i++) begin
          mbuf[1 - m_front][i]   = 3'b000;
          mknown[1 - m_front][i] = 1'b1;
        end
`endif
      end else if (m_pending == 0 && swap_req) begin
        m_pending = 1;
      end
      m_yprev = y;
    end
  end

  // Compare every cycle, just after the edge.
  always @(posedge CLOCK_25) begin
    #1;
    if (exp_known) begin
      chk("model_r", r, exp_r);
      chk("model_g", g, exp_g);
      chk("model_b", b, exp_b);
    end
    chk("model_front_sel", front_sel, m_front);
    chk("model_swap_pending", swap_pending, m_pending);
    chk("model_busy", busy, (m_busy_left > 0) ? 1 : 0);
    chk("model_wr_ready", wr_ready, (m_busy_left > 0) ? 0 : 1);
  end

  task automatic wr(input int px, input int py, input logic [2:0] c);
    @(negedge CLOCK_25);
    wr_en = 1'b1; wr_x = 10'(px); wr_y = 9'(py); wr_color = c;
    @(negedge CLOCK_25);
    wr_en = 1'b0;
    $display("WR x=%0d y=%0d color=%b", px, py, c);
  endtask

  task automatic rd(input string nm, input int px, input int py,
                    input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    @(negedge CLOCK_25);
    x = 10'(px); y = 9'(py);
    @(posedge CLOCK_25);
    #1;
    $display("RD x=%0d y=%0d r=%02h g=%02h b=%02h", px, py, r, g, b);
    chk({nm, "_r"}, r, er);
    chk({nm, "_g"}, g, eg);
    chk({nm, "_b"}, b, eb);
  endtask

  task automatic pulse_swap;
    @(negedge CLOCK_25);
    swap_req = 1'b1;
    @(negedge CLOCK_25);
    swap_req = 1'b0;
    $display("SWAP_REQ");
  endtask

  // Drive y 119 -> 0; returns just after the boundary edge.
  task automatic boundary;
    @(negedge CLOCK_25);
    y = 9'd119;
    @(negedge CLOCK_25);
    y = 9'd0;
    @(posedge CLOCK_25);
    #1;
    $display("BOUNDARY front_sel=%0d pending=%0d", front_sel, swap_pending);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; x = '0; y = '0; wr_en = 1'b0; wr_x = '0; wr_y = '0;
    wr_color = '0; swap_req = 1'b0;

    // 1. reset state
    @(posedge CLOCK_25);
    #1;
    chk("reset_r", r, 0);
    chk("reset_g", g, 0);
    chk("reset_b", b, 0);
    chk("reset_front_sel", front_sel, 0);
    chk("reset_swap_pending", swap_pending, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_ready", wr_ready, 1);
    @(negedge CLOCK_25);
    reset = 1'b0;
    @(posedge CLOCK_25);
    #1;
    chk("post_reset_front_sel", front_sel, 0);
    chk("post_reset_wr_ready", wr_ready, 1);

    // 2. write back buffer, swap at boundary, read it back
    wr(5, 7, 3'b101);
    pulse_swap();
    chk("t2_pending", swap_pending, 1);
    chk("t2_front_before", front_sel, 0);
    boundary();
    chk("t2_front_after", front_sel, 1);
    chk("t2_pending_after", swap_pending, 0);
    rd("t2_pix", 5, 7, 8'hFF, 8'h00, 8'hFF);

    // 3. out-of-range writes dropped, out-of-range reads give zero
    wr(0, 0, 3'b010);
    wr(0, 1, 3'b001);
    wr(40, 1, 3'b111);
    wr(32, 95, 3'b100);
    wr(160, 0, 3'b111);
    wr(0, 120, 3'b111);
    wr(32, 300, 3'b011);
    pulse_swap();
    boundary();
    chk("t3_front", front_sel, 0);
    rd("t3_p00", 0, 0, 8'h00, 8'hFF, 8'h00);
    rd("t3_p01", 0, 1, 8'h00, 8'h00, 8'hFF);
    rd("t3_p32_95", 32, 95, 8'hFF, 8'h00, 8'h00);
    rd("t3_x200", 200, 0, 8'h00, 8'h00, 8'h00);
    rd("t3_y120", 0, 120, 8'h00, 8'h00, 8'h00);
    rd("t3_p40_1", 40, 1, 8'hFF, 8'hFF, 8'hFF);

    // 4. several requests in one frame -> one toggle
    @(negedge CLOCK_25);
    y = 9'd50;
    pulse_swap();
    pulse_swap();
    pulse_swap();
    chk("t4_pending", swap_pending, 1);
    boundary();
    chk("t4_front_once", front_sel, 1);
    boundary();
    chk("t4_front_no_second", front_sel, 1);
    chk("t4_pending_clear", swap_pending, 0);

`ifdef FB_CLEAR_EN
    // 5. clear sequencer timing, writes ignored, swap deferred past busy
    begin
      int cyc0;
      pulse_swap();
      boundary();
      cyc0 = cyc;
      chk("t5_front", front_sel, 0);
      chk("t5_busy", busy, 1);
      chk("t5_wr_ready", wr_ready, 0);
      wr(0, 0, 3'b111);
      pulse_swap();
      boundary();
      chk("t5_front_held", front_sel, 0);
      chk("t5_pending_held", swap_pending, 1);
      while (busy && (cyc - cyc0) < 25000) begin
        @(posedge CLOCK_25);
        #1;
      end
      chk("t5_busy_cycles", cyc - cyc0, 19200);
      chk("t5_ready_back", wr_ready, 1);
      boundary();
      chk("t5_front_swapped", front_sel, 1);
      rd("t5_cleared", 0, 0, 8'h00, 8'h00, 8'h00);

      // 6. reset in the middle of a clear
      repeat (50) @(negedge CLOCK_25);
      chk("t6_busy_mid", busy, 1);
      @(negedge CLOCK_25);
      reset = 1'b1;
      @(posedge CLOCK_25);
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_wr_ready", wr_ready, 1);
      chk("t6_front", front_sel, 0);
      chk("t6_pending", swap_pending, 0);
      @(negedge CLOCK_25);
      reset = 1'b0;
    end
`endif

    repeat (5) @(negedge CLOCK_25);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
